// File: rtl/regfile_scoreboard.sv
// Integer register file with two combinational read ports, one writeback port,
// a per-register pending-write scoreboard and a post-reset sequential clear engine.
module regfile_scoreboard #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            ready
);

   localparam bit ZERO_EN = (ZERO_REG != 0);
   localparam bit BYP_EN  = (BYPASS != 0);

   typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

   state_t            state_r;
   logic [AW-1:0]     cnt_r;
   logic [NREGS-1:0]  pending_r;
   logic [NREGS-1:0]  pending_next_s;
   logic [XLEN-1:0]   regs_r [NREGS];
   logic              issue_set_s;
   logic              wb_we_s;

   function automatic logic [XLEN-1:0] read_sel(
      input logic [AW-1:0]   addr,
      input logic [XLEN-1:0] stored,
      input logic            wv,
      input logic [AW-1:0]   wrd,
      input logic [XLEN-1:0] wdata
   );
      logic [XLEN-1:0] v;
      if (ZERO_EN && (addr == '0)) begin
         v = '0;
      end else if (BYP_EN && wv && (wrd == addr)) begin
         v = wdata;
      end else begin
         v = stored;
      end
      return v;
   endfunction

   // A forwarded writeback retires the producer in the same cycle, so busy is masked.
   function automatic logic busy_sel(
      input logic [AW-1:0] addr,
      input logic          pend,
      input logic          wv,
      input logic [AW-1:0] wrd
   );
      logic b;
      if (ZERO_EN && (addr == '0)) begin
         b = 1'b0;
      end else if (BYP_EN && wv && (wrd == addr)) begin
         b = 1'b0;
      end else begin
         b = pend;
      end
      return b;
   endfunction

   // Write enables; register 0 is never written nor tracked when hardwired.
   always_comb begin
      issue_set_s = issue_valid & ~(ZERO_EN & (issue_rd == '0));
      wb_we_s     = wb_valid & ~(ZERO_EN & (wb_rd == '0));
   end

   // Next scoreboard: writeback clears first, issue sets last so a same-register issue wins.
   always_comb begin
      pending_next_s           = pending_r;
      pending_next_s[wb_rd]    = pending_r[wb_rd] & ~wb_valid;
      pending_next_s[issue_rd] = pending_next_s[issue_rd] | issue_set_s;
   end

   // Control FSM: clear sweep after reset, then normal operation with scoreboard updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_CLEAR;
         cnt_r     <= '0;
         ready     <= 1'b0;
         pending_r <= '0;
      end else begin
         case (state_r)
            ST_CLEAR: begin
               cnt_r <= cnt_r + AW'(1);
               if (cnt_r == AW'(NREGS - 1)) begin
                  state_r <= ST_RUN;
                  ready   <= 1'b1;
               end
            end
            ST_RUN: begin
               pending_r <= pending_next_s;
            end
            default: begin
               state_r   <= ST_CLEAR;
               cnt_r     <= '0;
               ready     <= 1'b0;
               pending_r <= '0;
            end
         endcase
      end
   end

   // Register array: zeroed one entry per cycle during clear, written back during run.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_r == ST_CLEAR) begin
            regs_r[cnt_r] <= '0;
         end else if (wb_we_s) begin
            regs_r[wb_rd] <= wb_data;
         end
      end
   end

   // Read ports and busy flags; all forced low until the clear sweep finishes.
   always_comb begin
      rd1      = '0;
      rd2      = '0;
      rs1_busy = 1'b0;
      rs2_busy = 1'b0;
      if (state_r == ST_RUN) begin
         rd1      = read_sel(rs1_addr, regs_r[rs1_addr], wb_valid, wb_rd, wb_data);
         rd2      = read_sel(rs2_addr, regs_r[rs2_addr], wb_valid, wb_rd, wb_data);
         rs1_busy = busy_sel(rs1_addr, pending_r[rs1_addr], wb_valid, wb_rd);
         rs2_busy = busy_sel(rs2_addr, pending_r[rs2_addr], wb_valid, wb_rd);
      end else begin
         rd1      = '0;
         rd2      = '0;
         rs1_busy = 1'b0;
         rs2_busy = 1'b0;
      end
   end

endmodule
